// File: rtl/codec_init_sequencer.sv
// Power-up command sequencer for the ADAU1761 I2C register controller: walks an
// external command ROM issuing register writes, polled reads and timed delays.
module codec_init_sequencer #(
    parameter int          C_NUM_CMDS   = 64,
    parameter int          C_IDX_W      = 6,
    parameter logic [15:0] C_DELAY_UNIT = 16'd1000,
    parameter logic [7:0]  C_POLL_MAX   = 8'd16,
    parameter logic [23:0] C_TIMEOUT    = 24'd100000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [C_IDX_W-1:0] err_index,
    output logic [C_IDX_W-1:0] cmd_index,
    input  logic [25:0]        cmd_entry,
    output logic               i2c_valid,
    output logic               i2c_rnw,
    output logic [15:0]        i2c_address,
    output logic [7:0]         i2c_wdata,
    input  logic               i2c_ready,
    input  logic [7:0]         i2c_rdata
);

    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_POLL  = 2'd2;
    localparam logic [1:0] OP_DELAY = 2'd3;
    localparam logic [C_IDX_W-1:0] LAST_IDX = C_IDX_W'(C_NUM_CMDS - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_FETCH, ST_ISSUE, ST_WAIT_BUSY, ST_WAIT_DONE,
        ST_CHECK, ST_DELAY, ST_ADVANCE, ST_DONE, ST_FAIL
    } state_t;

    state_t      state_r;
    logic [7:0]  mask_r;
    logic [7:0]  rdata_r;
    logic [7:0]  tries_r;
    logic [7:0]  ticks_r;
    logic [15:0] pre_r;
    logic [23:0] tmo_r;
    logic        retry_r;
    logic        tmo_hit_s;

    function automatic logic poll_match(input logic [7:0] rdata, input logic [7:0] mask);
        return (rdata & mask) == mask;
    endfunction

    assign tmo_hit_s = (tmo_r == (C_TIMEOUT - 24'd1));

    // Sequencer state machine; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_index   <= '0;
            cmd_index   <= '0;
            i2c_valid   <= 1'b0;
            i2c_rnw     <= 1'b0;
            i2c_address <= 16'd0;
            i2c_wdata   <= 8'd0;
            mask_r      <= 8'd0;
            rdata_r     <= 8'd0;
            tries_r     <= 8'd0;
            ticks_r     <= 8'd0;
            pre_r       <= 16'd0;
            tmo_r       <= 24'd0;
            retry_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start) begin
                        done      <= 1'b0;
                        error     <= 1'b0;
                        err_index <= '0;
                        cmd_index <= '0;
                        busy      <= 1'b1;
                        state_r   <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    mask_r <= cmd_entry[7:0];
                    case (cmd_entry[25:24])
                        OP_WRITE, OP_POLL: begin
                            i2c_valid   <= 1'b1;
                            i2c_rnw     <= (cmd_entry[25:24] == OP_POLL);
                            i2c_address <= cmd_entry[23:8];
                            i2c_wdata   <= cmd_entry[7:0];
                            tries_r     <= 8'd1;
                            state_r     <= ST_ISSUE;
                        end
                        OP_DELAY: begin
                            if (cmd_entry[7:0] == 8'd0) begin
                                state_r <= ST_ADVANCE;
                            end else begin
                                ticks_r <= cmd_entry[7:0];
                                pre_r   <= 16'd0;
                                retry_r <= 1'b0;
                                state_r <= ST_DELAY;
                            end
                        end
                        default: begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_r <= ST_DONE;
                        end
                    endcase
                end
                ST_ISSUE: begin
                    if (i2c_ready) begin
                        i2c_valid <= 1'b0;
                        tmo_r     <= 24'd0;
                        state_r   <= ST_WAIT_BUSY;
                    end
                end
                // Controller ready is one register behind the accept, so wait for it to drop first.
                ST_WAIT_BUSY: begin
                    if (!i2c_ready) begin
                        tmo_r   <= tmo_r + 24'd1;
                        state_r <= ST_WAIT_DONE;
                    end else if (tmo_hit_s) begin
                        busy      <= 1'b0;
                        error     <= 1'b1;
                        err_index <= cmd_index;
                        state_r   <= ST_FAIL;
                    end else begin
                        tmo_r <= tmo_r + 24'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (i2c_ready) begin
                        rdata_r <= i2c_rdata;
                        state_r <= i2c_rnw ? ST_CHECK : ST_ADVANCE;
                    end else if (tmo_hit_s) begin
                        busy      <= 1'b0;
                        error     <= 1'b1;
                        err_index <= cmd_index;
                        state_r   <= ST_FAIL;
                    end else begin
                        tmo_r <= tmo_r + 24'd1;
                    end
                end
                ST_CHECK: begin
                    if (poll_match(rdata_r, mask_r)) begin
                        state_r <= ST_ADVANCE;
                    end else if (tries_r == C_POLL_MAX) begin
                        busy      <= 1'b0;
                        error     <= 1'b1;
                        err_index <= cmd_index;
                        state_r   <= ST_FAIL;
                    end else begin
                        tries_r <= tries_r + 8'd1;
                        ticks_r <= 8'd1;
                        pre_r   <= 16'd0;
                        retry_r <= 1'b1;
                        state_r <= ST_DELAY;
                    end
                end
                // A poll retry re-issues the held request rather than re-reading the table.
                ST_DELAY: begin
                    if (pre_r == (C_DELAY_UNIT - 16'd1)) begin
                        pre_r <= 16'd0;
                        if (ticks_r == 8'd1) begin
                            if (retry_r) begin
                                i2c_valid <= 1'b1;
                                state_r   <= ST_ISSUE;
                            end else begin
                                state_r <= ST_ADVANCE;
                            end
                        end else begin
                            ticks_r <= ticks_r - 8'd1;
                        end
                    end else begin
                        pre_r <= pre_r + 16'd1;
                    end
                end
                ST_ADVANCE: begin
                    if (cmd_index == LAST_IDX) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        cmd_index <= cmd_index + C_IDX_W'(1);
                        state_r   <= ST_FETCH;
                    end
                end
                default: begin
                    i2c_valid <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Directed bench for codec_init_sequencer with a command ROM and a behavioural
// I2C controller whose ready lags the accept by one cycle.
module tb_codec_init_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, error;
    logic [2:0]  err_index, cmd_index;
    logic [25:0] cmd_entry;
    logic        i2c_valid, i2c_rnw, i2c_ready;
    logic [15:0] i2c_address;
    logic [7:0]  i2c_wdata, i2c_rdata;

    logic [25:0] rom [0:7];
    logic [7:0]  resp_q [0:7];
    logic        m_ready;
    logic [7:0]  m_rdata;
    int          mst, bcnt, gcnt;
    int          n_acc = 0;
    int          acc_base = 0;
    bit          gap_en = 1'b0;
    bit          hang_en = 1'b0;
    int          hang_idx = 0;
    logic [15:0] log_addr [0:63];
    logic [7:0]  log_wdata [0:63];
    logic        log_rnw [0:63];
    int          log_cyc [0:63];
    int          cyc_cnt = 0;
    int          hold_seen = 0, hold_viol = 0, valid_cnt = 0;
    logic        pv = 1'b0, pr = 1'b0, prnw = 1'b0;
    logic [15:0] pa = 16'd0;
    logic [7:0]  pw = 8'd0;
    int          n_cmp = 0, n_err = 0;

    codec_init_sequencer #(
        .C_NUM_CMDS(8), .C_IDX_W(3), .C_DELAY_UNIT(16'd10),
        .C_POLL_MAX(8'd4), .C_TIMEOUT(24'd50)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .error(error), .err_index(err_index), .cmd_index(cmd_index),
        .cmd_entry(cmd_entry), .i2c_valid(i2c_valid), .i2c_rnw(i2c_rnw),
        .i2c_address(i2c_address), .i2c_wdata(i2c_wdata),
        .i2c_ready(i2c_ready), .i2c_rdata(i2c_rdata)
    );

    always #5 clk = ~clk;
    assign cmd_entry = rom[cmd_index];
    assign i2c_ready = m_ready;
    assign i2c_rdata = m_rdata;

    function automatic logic [25:0] ent(input logic [1:0] op, input logic [15:0] a, input logic [7:0] d);
        return {op, a, d};
    endfunction

    function automatic int ridx(input int v);
        if (v < 0 || v > 7) return 7;
        return v;
    endfunction

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Controller model: accept, one lag cycle with ready high, busy, then optional idle gap or hang.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready <= 1'b1; m_rdata <= 8'd0; mst <= 0; bcnt <= 0; gcnt <= 0;
        end else begin
            case (mst)
                0: if (i2c_valid && m_ready) begin
                    if (n_acc < 64) begin
                        log_addr[n_acc] <= i2c_address; log_wdata[n_acc] <= i2c_wdata;
                        log_rnw[n_acc] <= i2c_rnw; log_cyc[n_acc] <= cyc_cnt;
                    end
                    n_acc <= n_acc + 1; mst <= 1;
                end
                1: begin
                    m_ready <= 1'b0;
                    if (hang_en && (n_acc - 1 - acc_base) == hang_idx) mst <= 5;
                    else begin bcnt <= 2; mst <= 2; end
                end
                2: if (bcnt == 0) begin
                    m_ready <= 1'b1; m_rdata <= resp_q[ridx(n_acc - 1 - acc_base)];
                    mst <= gap_en ? 3 : 0;
                end else bcnt <= bcnt - 1;
                3: begin m_ready <= 1'b0; gcnt <= 3; mst <= 4; end
                4: if (gcnt == 0) begin m_ready <= 1'b1; mst <= 0; end else gcnt <= gcnt - 1;
                5: if (!hang_en) begin m_ready <= 1'b1; mst <= 0; end
                default: mst <= 0;
            endcase
        end
    end

    // Request-hold monitor: a stalled request must stay asserted and unchanged.
    always @(posedge clk) begin
        if (!rst_n) begin
            pv <= 1'b0;
        end else begin
            if (pv && !pr) begin
                hold_seen <= hold_seen + 1;
                if (!i2c_valid || i2c_address !== pa || i2c_wdata !== pw || i2c_rnw !== prnw)
                    hold_viol <= hold_viol + 1;
            end
            if (i2c_valid) valid_cnt <= valid_cnt + 1;
            pv <= i2c_valid; pr <= m_ready; pa <= i2c_address; pw <= i2c_wdata; prnw <= i2c_rnw;
        end
    end

    task automatic clear_rom();
        for (int i = 0; i < 8; i++) rom[i] = 26'd0;
        for (int i = 0; i < 8; i++) resp_q[i] = 8'd0;
    endtask

    task automatic start_seq();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output int cyc);
        cyc = 0;
        while (!done && !error && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (!done && !error) begin
            n_err++;
            $display("FAIL wait_end: neither done nor error after %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, error, err_index, cmd_index, i2c_valid, i2c_rnw, i2c_address, i2c_wdata} !== 35'd0) begin
            n_err++; $display("FAIL reset_outputs: outputs not all zero in reset (busy=%b done=%b error=%b)", busy, done, error);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, error, cmd_index, i2c_valid} !== 9'd0) begin
            n_err++; $display("FAIL reset_release: busy=%b done=%b error=%b cmd_index=%0d valid=%b, required all 0", busy, done, error, cmd_index, i2c_valid);
        end
    endtask

    task automatic test_write();
        int c, hs0, hv0;
        clear_rom();
        rom[0] = ent(2'd1, 16'h4000, 8'h01);
        rom[1] = ent(2'd1, 16'h4015, 8'h01);
        gap_en = 1'b1; acc_base = n_acc; hs0 = hold_seen; hv0 = hold_viol;
        start_seq();
        wait_end(400, c);
        n_cmp++;
        if (n_acc - acc_base !== 2) begin n_err++; $display("FAIL write_count: %0d accepts, required 2", n_acc - acc_base); end
        n_cmp++;
        if ({log_addr[acc_base], log_wdata[acc_base], log_rnw[acc_base]} !== {16'h4000, 8'h01, 1'b0}) begin
            n_err++; $display("FAIL write0: addr=%h data=%h rnw=%b, required 4000/01/0", log_addr[acc_base], log_wdata[acc_base], log_rnw[acc_base]);
        end
        n_cmp++;
        if ({log_addr[acc_base+1], log_wdata[acc_base+1], log_rnw[acc_base+1]} !== {16'h4015, 8'h01, 1'b0}) begin
            n_err++; $display("FAIL write1: addr=%h data=%h rnw=%b, required 4015/01/0", log_addr[acc_base+1], log_wdata[acc_base+1], log_rnw[acc_base+1]);
        end
        n_cmp++;
        if (hold_seen - hs0 < 1 || hold_viol != hv0) begin
            n_err++; $display("FAIL write_hold: stalled=%0d violations=%0d, required stalled>0 and violations 0", hold_seen - hs0, hold_viol - hv0);
        end
        n_cmp++;
        if ({done, busy, error} !== 3'b100) begin n_err++; $display("FAIL write_status: done/busy/error=%b%b%b, required 100", done, busy, error); end
        gap_en = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_delay();
        int c3, c0, v0;
        clear_rom();
        rom[0] = ent(2'd3, 16'h0000, 8'd3);
        v0 = valid_cnt;
        start_seq();
        wait_end(200, c3);
        n_cmp++;
        if ({done, error} !== 2'b10) begin n_err++; $display("FAIL delay_done: done=%b error=%b, required 1/0", done, error); end
        rom[0] = ent(2'd3, 16'h0000, 8'd0);
        start_seq();
        wait_end(200, c0);
        n_cmp++;
        if (c3 - c0 !== 30) begin n_err++; $display("FAIL delay_cycles: DELAY 3 took %0d extra cycles, required 30", c3 - c0); end
        n_cmp++;
        if (valid_cnt !== v0) begin n_err++; $display("FAIL delay_valid: i2c_valid high %0d cycles, required 0", valid_cnt - v0); end
    endtask

    task automatic test_poll_success();
        int c, n;
        clear_rom();
        rom[0] = ent(2'd2, 16'h4002, 8'h02);
        resp_q[0] = 8'h00; resp_q[1] = 8'h00; resp_q[2] = 8'h03;
        acc_base = n_acc;
        start_seq();
        wait_end(500, c);
        n = n_acc - acc_base;
        n_cmp++;
        if (n !== 3) begin n_err++; $display("FAIL poll_count: %0d reads, required 3", n); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({log_addr[acc_base+i], log_rnw[acc_base+i]} !== {16'h4002, 1'b1}) begin
                n_err++; $display("FAIL poll_req%0d: addr=%h rnw=%b, required 4002/1", i, log_addr[acc_base+i], log_rnw[acc_base+i]);
            end
        end
        // accept, lag 1, busy to ready at +4, capture +5, CHECK +6, 10-cycle tick, ISSUE +16, accept +17
        for (int i = 1; i < 3; i++) begin
            n_cmp++;
            if (log_cyc[acc_base+i] - log_cyc[acc_base+i-1] !== 17) begin
                n_err++; $display("FAIL poll_gap%0d: %0d cycles between reads, required 17", i, log_cyc[acc_base+i] - log_cyc[acc_base+i-1]);
            end
        end
        n_cmp++;
        if ({done, error} !== 2'b10) begin n_err++; $display("FAIL poll_done: done=%b error=%b, required 1/0", done, error); end
    endtask

    task automatic test_poll_exhaust();
        int c;
        clear_rom();
        rom[0] = ent(2'd2, 16'h4002, 8'h02);
        acc_base = n_acc;
        start_seq();
        wait_end(500, c);
        n_cmp++;
        if (n_acc - acc_base !== 4) begin n_err++; $display("FAIL exhaust_count: %0d reads, required 4", n_acc - acc_base); end
        n_cmp++;
        if ({error, done, err_index} !== {1'b1, 1'b0, 3'd0}) begin
            n_err++; $display("FAIL exhaust_status: error=%b done=%b err_index=%0d, required 1/0/0", error, done, err_index);
        end
    endtask

    task automatic test_timeout_restart();
        int c, w, d;
        clear_rom();
        rom[0] = ent(2'd1, 16'h4000, 8'hAA);
        rom[1] = ent(2'd1, 16'h4001, 8'h55);
        acc_base = n_acc; hang_idx = 1; hang_en = 1'b1;
        start_seq();
        w = 0;
        while (n_acc - acc_base < 2 && w < 200) begin @(negedge clk); w++; end
        repeat (5) @(negedge clk);
        start_seq();
        n_cmp++;
        if ({busy, error, cmd_index} !== {1'b1, 1'b0, 3'd1}) begin
            n_err++; $display("FAIL busy_start: busy=%b error=%b cmd_index=%0d, required 1/0/1", busy, error, cmd_index);
        end
        wait_end(300, c);
        d = cyc_cnt - log_cyc[acc_base+1];
        n_cmp++;
        if ({error, done, err_index} !== {1'b1, 1'b0, 3'd1}) begin
            n_err++; $display("FAIL timeout_status: error=%b done=%b err_index=%0d, required 1/0/1", error, done, err_index);
        end
        n_cmp++;
        if (d < 49 || d > 53) begin n_err++; $display("FAIL timeout_time: error %0d cycles after accept, required about 50", d); end
        hang_en = 1'b0;
        repeat (3) @(negedge clk);
        acc_base = n_acc;
        start_seq();
        n_cmp++;
        if ({error, busy, cmd_index} !== {1'b0, 1'b1, 3'd0}) begin
            n_err++; $display("FAIL restart: error=%b busy=%b cmd_index=%0d, required 0/1/0", error, busy, cmd_index);
        end
        wait_end(300, c);
        n_cmp++;
        if ({done, error} !== 2'b10 || n_acc - acc_base !== 2) begin
            n_err++; $display("FAIL restart_done: done=%b error=%b accepts=%0d, required 1/0/2", done, error, n_acc - acc_base);
        end
    endtask

    task automatic test_reset_no_end();
        int c, w;
        clear_rom();
        for (int i = 0; i < 8; i++) rom[i] = ent(2'd1, 16'h4100 + 16'(i), 8'(i));
        start_seq();
        w = 0;
        while (!i2c_valid && w < 50) begin @(negedge clk); w++; end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (i2c_valid !== 1'b0) begin n_err++; $display("FAIL async_reset_valid: i2c_valid=%b, required 0", i2c_valid); end
        n_cmp++;
        if ({busy, done, error, err_index, cmd_index, i2c_rnw, i2c_address, i2c_wdata} !== 34'd0) begin
            n_err++; $display("FAIL async_reset_outputs: busy=%b cmd_index=%0d addr=%h, required all 0", busy, cmd_index, i2c_address);
        end
        @(negedge clk) rst_n = 1'b1;
        acc_base = n_acc;
        start_seq();
        wait_end(600, c);
        n_cmp++;
        if ({done, error, busy, cmd_index} !== {1'b1, 1'b0, 1'b0, 3'd7}) begin
            n_err++; $display("FAIL no_end_done: done=%b error=%b busy=%b cmd_index=%0d, required 1/0/0/7", done, error, busy, cmd_index);
        end
        n_cmp++;
        if (n_acc - acc_base !== 8 || log_addr[acc_base+7] !== 16'h4107) begin
            n_err++; $display("FAIL no_end_writes: accepts=%0d last addr=%h, required 8/4107", n_acc - acc_base, log_addr[acc_base+7]);
        end
    endtask

    initial begin
        clear_rom();
        test_reset();
        test_write();
        test_delay();
        test_poll_success();
        test_poll_exhaust();
        test_timeout_restart();
        test_reset_no_end();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/codec_init_sequencer.md
Name: codec_init_sequencer

Overview:
- Upstream stage of the ADAU1761 I2C register controller.
- After power-up it walks a command table and issues single-byte register writes and polled reads (for example the PLL-lock check) through the controller's valid/ready interface.
- It inserts programmed delays and reports done or error to the audio top level.
- The command table sits outside the block as combinational ROM, indexed by cmd_index.

Parameters:
- C_NUM_CMDS, 64: number of table entries; 2 to 256.
- C_IDX_W, 6: width of cmd_index; must satisfy 2^C_IDX_W >= C_NUM_CMDS.
- C_DELAY_UNIT, 16'd1000: clk cycles per delay tick; must be >= 1.
- C_POLL_MAX, 8'd16: maximum POLL attempts before error; must be >= 1.
- C_TIMEOUT, 24'd100000: maximum cycles per controller transaction, measured from acceptance until ready returns.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: begin sequence; sampled only in IDLE, DONE or FAIL.
- busy, out, 1: sequence in progress.
- done, out, 1: sequence completed; held until next start.
- error, out, 1: sequence aborted; held until next start.
- err_index, out, C_IDX_W: index of the failing entry.
- cmd_index, out, C_IDX_W: table address.
- cmd_entry, in, 26: {op[25:24], addr[23:8], data[7:0]}. op encoding: 0=END, 1=WRITE, 2=POLL, 3=DELAY.
- i2c_valid, out, 1: request to controller.
- i2c_rnw, out, 1: 1=read.
- i2c_address, out, 16: register address.
- i2c_wdata, out, 8: write data.
- i2c_ready, in, 1: controller idle/accepting.
- i2c_rdata, in, 8: read data from controller.

Behaviour:
- Reset, asynchronous: all outputs 0, cmd_index=0, state IDLE. Reset mid-transaction drops i2c_valid immediately; the controller is reset separately.
- All outputs are registered. cmd_entry is sampled one cycle after cmd_index changes.
- IDLE/DONE/FAIL with start=1: clear done, error and err_index; set cmd_index=0, busy=1; go to FETCH. start while busy is ignored.
- FETCH: latch cmd_entry, then dispatch on op.
  - WRITE: ISSUE with rnw=0.
  - POLL: ISSUE with rnw=1, attempt count=1.
  - DELAY with data=0: ADVANCE.
  - DELAY with data!=0: DELAY, tick count=data.
  - END: DONE.
- ISSUE: drive i2c_valid=1 with address, wdata and rnw held stable until the cycle where i2c_valid&&i2c_ready. That is the accept cycle; then go to WAIT_BUSY.
- WAIT_BUSY: the controller's ready lags by one registered cycle, so ready may still read 1 here. Wait for i2c_ready=0, then go to WAIT_DONE.
- WAIT_DONE: wait for i2c_ready=1. For a write, go to ADVANCE. For a read, capture i2c_rdata in that same cycle and go to CHECK.
- Timeout: a counter runs from the accept cycle through WAIT_BUSY and WAIT_DONE. If it reaches C_TIMEOUT, go to FAIL.
- CHECK: match means (rdata & data) == data.
  - Match: ADVANCE.
  - No match with attempts == C_POLL_MAX: FAIL.
  - Otherwise: increment attempts, DELAY for 1 tick, return to ISSUE with the same entry. Do not re-fetch.
- DELAY: a prescaler counts C_DELAY_UNIT cycles per tick. Exit after data ticks, or after 1 tick on a poll retry. Exactly data*C_DELAY_UNIT cycles are spent in DELAY.
- ADVANCE:
  - cmd_index == C_NUM_CMDS-1: go to DONE. An implicit END; there is no wrap.
  - Otherwise: increment cmd_index, go to FETCH.
- DONE: busy=0, done=1.
- FAIL: busy=0, error=1, err_index=cmd_index. i2c_valid is 0 in every state except ISSUE.
- Controller-side errors: NACK is not visible to this block; a hung controller is caught by the timeout.

Test Plan:
- Write sequence: table {WRITE 0x4000/0x01, WRITE 0x4015/0x01, END}, pulse start. Required: exactly 2 accepts with the listed addr/data and rnw=0, each held until ready, then done=1, busy=0, error=0.
- Delay: {DELAY 3, END}, C_DELAY_UNIT=10. Required: exactly 30 cycles spent in DELAY, no i2c_valid, done=1.
- Poll success on 3rd try: {POLL 0x4002 mask 0x02, END}. Model returns rdata 0x00, 0x00, then 0x03. Required: 3 read transactions, 1 tick between each, done=1.
- Poll exhaustion: C_POLL_MAX=4, rdata always 0x00. Required: 4 reads, then error=1, err_index=0, done=0.
- Timeout and restart: model holds ready=0 after accept of entry 1, C_TIMEOUT=50. Required: error=1, err_index=1. start asserted mid-run is ignored. start after FAIL clears error and restarts from cmd_index=0.
- Reset and no-END table: assert rst_n=0 during ISSUE. Required: i2c_valid falls without waiting for a clock edge, all outputs 0. Then run a table of C_NUM_CMDS WRITEs with no END: required done after the last entry, cmd_index=C_NUM_CMDS-1.
